// File: rtl/imgpre_pkg.sv
// Shared types and helpers for the image preprocessing front end.
// The RGB565 expansion lives here so a transmitter can reuse the same rule.
package imgpre_pkg;

   localparam int PIX_W   = 8;
   localparam int WIDTH_W = 12;

   typedef enum logic [1:0] {
      ST_SKIP    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_ACTIVE  = 2'd2
   } dvp_state_t;

   // Widen each channel by replicating its top bits into the new LSBs.
   function automatic logic [3*PIX_W-1:0] rgb565_to_888(input logic [15:0] pix);
      logic [4:0] r5;
      logic [5:0] g6;
      logic [4:0] b5;
      r5 = pix[15:11];
      g6 = pix[10:5];
      b5 = pix[4:0];
      return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
   endfunction

endpackage

// File: rtl/dvp_sync_edge.sv
// Registers the camera frame/line syncs once and flags their edges by
// comparing the registered value with its previous sample.
module dvp_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic cam_vsync,
   input  logic cam_href,
   output logic vs_rise,
   output logic vs_fall,
   output logic href_rise,
   output logic href_fall
);

   logic vs_q, vs_prev, href_q, href_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q      <= 1'b0;
         vs_prev   <= 1'b0;
         href_q    <= 1'b0;
         href_prev <= 1'b0;
      end else begin
         vs_q      <= cam_vsync;
         vs_prev   <= vs_q;
         href_q    <= cam_href;
         href_prev <= href_q;
      end
   end

   assign vs_rise   =  vs_q   & ~vs_prev;
   assign vs_fall   = ~vs_q   &  vs_prev;
   assign href_rise =  href_q & ~href_prev;
   assign href_fall = ~href_q &  href_prev;

endmodule

// File: rtl/dvp_rgb565_rx.sv
// DVP RGB565 receiver: frame skipping, byte pairing, 565->888 expansion,
// line-length checking. Handshake: din_valid is a one-cycle strobe, no ready.
module dvp_rgb565_rx
   import imgpre_pkg::*;
#(
   parameter int SKIP_FRAMES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cam_vsync,
   input  logic         cam_href,
   input  logic         cam_de,
   input  logic [7:0]   cam_data,
   input  logic [11:0]  img_width,
   output logic         din_valid,
   output logic [7:0]   r_data,
   output logic [7:0]   g_data,
   output logic [7:0]   b_data,
   output logic         frame_start,
   output logic         line_last,
   output logic         err_width,
   output logic [1:0]   state_dbg
);

   localparam logic [3:0] SKIP_N    = 4'(SKIP_FRAMES);
   localparam dvp_state_t RST_STATE = (SKIP_FRAMES == 0) ? ST_WAIT_VS : ST_SKIP;

   dvp_state_t          state, state_nxt;
   logic [3:0]          skip_cnt;
   logic                phase, armed;
   logic [7:0]          hi_byte;
   logic [WIDTH_W-1:0]  pix_cnt, width_q;
   logic                vs_rise, vs_fall, href_rise, href_fall;
   logic                byte_stb, eff_phase;
   logic [WIDTH_W-1:0]  eff_cnt, eff_width;
   logic [3*PIX_W-1:0]  rgb;

   dvp_sync_edge u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .cam_vsync (cam_vsync),
      .cam_href  (cam_href),
      .vs_rise   (vs_rise),
      .vs_fall   (vs_fall),
      .href_rise (href_rise),
      .href_fall (href_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RST_STATE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_SKIP:    if (vs_rise && (skip_cnt + 4'd1 == SKIP_N)) state_nxt = ST_WAIT_VS;
         ST_WAIT_VS: if (vs_fall) state_nxt = ST_ACTIVE;
         ST_ACTIVE:  if (vs_rise) state_nxt = ST_WAIT_VS;
         default:    state_nxt = RST_STATE;
      endcase
   end

   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          skip_cnt <= 4'd0;
      else if (state != ST_SKIP)           skip_cnt <= 4'd0;
      else if (vs_rise)                    skip_cnt <= skip_cnt + 4'd1;
   end

   // The registered href rise lags the raw line by a cycle, so a byte landing
   // in that same cycle must already see the cleared phase/count/width.
   assign byte_stb  = (state == ST_ACTIVE) && cam_href && cam_de && !vs_rise;
   assign eff_phase = href_rise ? 1'b0 : phase;
   assign eff_cnt   = href_rise ? '0 : pix_cnt;
   assign eff_width = href_rise ? img_width : width_q;
   assign rgb       = rgb565_to_888({hi_byte, cam_data});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_valid   <= 1'b0;
         r_data      <= '0;
         g_data      <= '0;
         b_data      <= '0;
         frame_start <= 1'b0;
         line_last   <= 1'b0;
         err_width   <= 1'b0;
         phase       <= 1'b0;
         armed       <= 1'b0;
         hi_byte     <= '0;
         pix_cnt     <= '0;
         width_q     <= '0;
      end else begin
         din_valid   <= 1'b0;
         frame_start <= 1'b0;
         line_last   <= 1'b0;
         err_width   <= 1'b0;

         if (href_rise) begin
            width_q <= img_width;
            pix_cnt <= '0;
            phase   <= 1'b0;
         end
         if (state != ST_ACTIVE || vs_rise) phase <= 1'b0;
         if (state == ST_WAIT_VS && vs_fall) armed <= 1'b1;

         if (byte_stb) begin
            if (!eff_phase) begin
               hi_byte <= cam_data;
               phase   <= 1'b1;
            end else begin
               phase       <= 1'b0;
               din_valid   <= 1'b1;
               r_data      <= rgb[23:16];
               g_data      <= rgb[15:8];
               b_data      <= rgb[7:0];
               frame_start <= armed;
               armed       <= 1'b0;
               line_last   <= (eff_cnt == eff_width - 12'd1);
               pix_cnt     <= eff_cnt + 12'd1;
            end
         end

         // A vsync rise ending the frame mid-line is not a width error.
         if (href_fall && state == ST_ACTIVE && !vs_rise) begin
            err_width <= (pix_cnt != width_q) || phase;
            phase     <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dvp_rgb565_rx.sv
// Directed bench for dvp_rgb565_rx: frame skipping, colour expansion,
// line-length errors, vsync mid-line and reset mid-frame.
module tb_dvp_rgb565_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cam_vsync = 1'b0;
   logic        cam_href = 1'b0;
   logic        cam_de = 1'b0;
   logic [7:0]  cam_data = 8'h00;
   logic [11:0] img_width = 12'd4;
   logic        din_valid;
   logic [7:0]  r_data, g_data, b_data;
   logic        frame_start, line_last, err_width;
   logic [1:0]  state_dbg;

   dvp_rgb565_rx #(.SKIP_FRAMES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_de      (cam_de),
      .cam_data    (cam_data),
      .img_width   (img_width),
      .din_valid   (din_valid),
      .r_data      (r_data),
      .g_data      (g_data),
      .b_data      (b_data),
      .frame_start (frame_start),
      .line_last   (line_last),
      .err_width   (err_width),
      .state_dbg   (state_dbg)
   );

   // clock / cycle counter / watchdog
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   // hand-computed RGB565 -> RGB888 vectors
   logic [7:0]  hi_tab [8] = '{8'hF8, 8'h07, 8'h00, 8'hFF, 8'h12, 8'hA5, 8'h84, 8'h7B};
   logic [7:0]  lo_tab [8] = '{8'h00, 8'hE0, 8'h1F, 8'hFF, 8'h34, 8'h5A, 8'h10, 8'hEF};
   logic [23:0] rgb_tab[8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF,
                               24'h1045A5, 24'hA5AAD6, 24'h848284, 24'h7B7D7B};

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard: {frame_start, line_last, rgb} plus the cycle it must appear in
   logic [25:0] exp_q[$];
   int          exp_t_q[$];
   int          pix_seen = 0;
   int          err_seen = 0;
   int          last_err_cyc = 0;
   bit          emit = 1'b0;
   bit          fs_pending = 1'b0;
   int          line_w = 4;

   always @(negedge clk) begin
      if (rst_n) begin
         if (din_valid) begin
            pix_seen++;
            if (exp_q.size() == 0) begin
               check("pix_spurious", 32'(exp_q.size()), 32'd1);
            end else begin
               logic [25:0] e;
               int t;
               e = exp_q.pop_front();
               t = exp_t_q.pop_front();
               check("pix", 32'({frame_start, line_last, r_data, g_data, b_data}), 32'(e));
               check("pix_lat", 32'(cyc), 32'(t));
            end
         end
         if (err_width) begin
            err_seen++;
            last_err_cyc = cyc;
         end
      end
   end

   // driver tasks: inputs change on the falling edge
   task automatic send_line(input int first, input int npix, input bit odd_byte, input bit exp_err);
      int e0, c_fall;
      logic ll;
      e0 = err_seen;
      @(negedge clk); cam_href = 1'b1; cam_de = 1'b0;
      @(negedge clk);
      for (int i = 0; i < npix; i++) begin
         @(negedge clk); cam_de = 1'b1; cam_data = hi_tab[(first + i) % 8];
         @(negedge clk); cam_data = lo_tab[(first + i) % 8];
         if (emit) begin
            ll = (i == line_w - 1);
            exp_q.push_back({fs_pending, ll, rgb_tab[(first + i) % 8]});
            exp_t_q.push_back(cyc + 1);
            fs_pending = 1'b0;
         end
      end
      if (odd_byte) begin
         @(negedge clk); cam_data = 8'hAB;
      end
      @(negedge clk); cam_de = 1'b0; cam_href = 1'b0; c_fall = cyc;
      repeat (5) @(negedge clk);
      check("err_cnt", 32'(err_seen - e0), 32'(exp_err));
      if (exp_err) check("err_lat", 32'(last_err_cyc), 32'(c_fall + 2));
   endtask

   task automatic vsync_pulse();
      @(negedge clk); cam_vsync = 1'b1;
      repeat (4) @(negedge clk);
      cam_vsync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   // a frame is its lines followed by the blanking pulse that ends it
   task automatic send_frame();
      send_line(0, 4, 1'b0, 1'b0);
      send_line(4, 4, 1'b0, 1'b0);
      vsync_pulse();
   endtask

   initial begin
      int p0, e0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_outs", 32'({din_valid, frame_start, line_last, err_width, r_data, g_data, b_data}), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      rst_n = 1'b1;

      // two settling frames produce nothing, third frame is delivered
      p0 = pix_seen;
      send_frame();
      send_frame();
      check("skip_pix", 32'(pix_seen - p0), 32'd0);
      check("state_active", 32'(state_dbg), 32'd2);
      emit = 1'b1; fs_pending = 1'b1;
      p0 = pix_seen;
      send_frame();
      check("frame3_pix", 32'(pix_seen - p0), 32'd8);

      // short line, long line, odd-byte line, then a clean line
      fs_pending = 1'b1;
      send_line(0, 3, 1'b0, 1'b1);
      send_line(0, 5, 1'b0, 1'b1);
      send_line(4, 3, 1'b1, 1'b1);
      send_line(0, 4, 1'b0, 1'b0);
      vsync_pulse();

      // vsync rises right after the first byte of pixel 2
      fs_pending = 1'b1;
      e0 = err_seen;
      @(negedge clk); cam_href = 1'b1; cam_de = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); cam_de = 1'b1; cam_data = hi_tab[i];
         @(negedge clk); cam_data = lo_tab[i];
         exp_q.push_back({fs_pending, 1'b0, rgb_tab[i]});
         exp_t_q.push_back(cyc + 1);
         fs_pending = 1'b0;
      end
      @(negedge clk); cam_data = hi_tab[2];
      @(negedge clk); cam_de = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1;
      repeat (5) @(negedge clk);
      check("vs_mid_err", 32'(err_seen - e0), 32'd0);
      emit = 1'b0;
      p0 = pix_seen;
      send_line(0, 4, 1'b0, 1'b0);
      check("vs_high_pix", 32'(pix_seen - p0), 32'd0);
      @(negedge clk); cam_vsync = 1'b0;
      repeat (4) @(negedge clk);
      emit = 1'b1; fs_pending = 1'b1;
      send_line(4, 4, 1'b0, 1'b0);
      vsync_pulse();

      // reset for one cycle right as a pixel comes out
      @(negedge clk); cam_href = 1'b1; cam_de = 1'b0;
      @(negedge clk);
      @(negedge clk); cam_de = 1'b1; cam_data = hi_tab[0];
      @(negedge clk); cam_data = lo_tab[0];
      @(posedge clk); #1;
      check("pre_rst_pix", 32'({din_valid, r_data, g_data, b_data}), {8'h01, 24'hFF0000});
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_outs", 32'({din_valid, frame_start, line_last, err_width, r_data, g_data, b_data}), 32'd0);
      check("mid_rst_state", 32'(state_dbg), 32'd0);
      @(negedge clk); cam_de = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); cam_href = 1'b0;
      repeat (4) @(negedge clk);
      emit = 1'b0;
      p0 = pix_seen;
      send_line(0, 4, 1'b0, 1'b0);
      vsync_pulse();
      send_frame();
      check("rst_skip_pix", 32'(pix_seen - p0), 32'd0);
      emit = 1'b1; fs_pending = 1'b1;
      p0 = pix_seen;
      send_frame();
      check("rst_resume_pix", 32'(pix_seen - p0), 32'd8);

      repeat (4) @(negedge clk);
      check("exp_q_left", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
